// File: rtl/range_union_count.sv
// range_union_count
//   Consumes a stream of inclusive ID ranges, sorted ascending by their low
//   bound. It reports how many distinct IDs the union covers and how many
//   disjoint intervals make up that union.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   start_in        pulse: clear all results and open a new stream
//   pair_valid_in   pair_in carries a range this cycle
//   pair_in         {first, second}, an inclusive range
//   stream_done_in  pulse: no further pairs follow
//   pair_ready_out  a pair is accepted this cycle (RUN only)
//   total_out       number of distinct IDs covered by the union
//   intervals_out   number of disjoint intervals in the union
//   done_out        total_out and intervals_out hold final values
//   bad_pair_out    sticky: a pair with first > second was dropped
//   order_err_out   sticky: a pair arrived below the current interval low
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_in; inputs ignored
// RUN   | accepting pairs and merging them into the open interval
// FLUSH | closing out the open interval (one cycle)
// DONE  | results final and held until start_in or reset

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package range_union_pkg;
  typedef struct packed {
    logic [`DATA_WIDTH-1:0] first;
    logic [`DATA_WIDTH-1:0] second;
  } tuple_pair_t;
endpackage

module range_union_count
  import range_union_pkg::*;
#(
  parameter int SUM_WIDTH = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_in,
  input  logic                 pair_valid_in,
  input  tuple_pair_t          pair_in,
  input  logic                 stream_done_in,
  output logic                 pair_ready_out,
  output logic [SUM_WIDTH-1:0] total_out,
  output logic [CNT_WIDTH-1:0] intervals_out,
  output logic                 done_out,
  output logic                 bad_pair_out,
  output logic                 order_err_out
);

  localparam int DW = `DATA_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state;
  logic                have_cur;
  logic [DW-1:0]       cur_lo;
  logic [DW-1:0]       cur_hi;

  logic [DW-1:0]       first;
  logic [DW-1:0]       second;
  logic                is_bad;
  logic                early;
  logic [DW-1:0]       eff_first;
  logic                merge;
  logic [DW-1:0]       new_hi;
  logic [SUM_WIDTH-1:0] span;

  assign first  = pair_in.first;
  assign second = pair_in.second;
  assign is_bad = first > second;

  // A pair starting below the open interval is treated as starting at its low
  // bound, so it always merges.
  assign early     = have_cur && (first < cur_lo);
  assign eff_first = early ? cur_lo : first;

  // One extra bit so that cur_hi = all-ones does not wrap to zero and still
  // lets adjacent/overlapping pairs merge.
  assign merge  = {1'b0, eff_first} <= ({1'b0, cur_hi} + (DW+1)'(1));
  assign new_hi = (second > cur_hi) ? second : cur_hi;
  assign span   = SUM_WIDTH'(cur_hi) - SUM_WIDTH'(cur_lo) + SUM_WIDTH'(1);

  assign pair_ready_out = (state == RUN);
  assign done_out       = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      have_cur      <= 1'b0;
      cur_lo        <= '0;
      cur_hi        <= '0;
      total_out     <= '0;
      intervals_out <= '0;
      bad_pair_out  <= 1'b0;
      order_err_out <= 1'b0;
    end else if (start_in) begin
      state         <= RUN;
      have_cur      <= 1'b0;
      total_out     <= '0;
      intervals_out <= '0;
      bad_pair_out  <= 1'b0;
      order_err_out <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (pair_valid_in) begin
            if (is_bad) begin
              bad_pair_out <= 1'b1;
            end else if (!have_cur) begin
              cur_lo   <= first;
              cur_hi   <= second;
              have_cur <= 1'b1;
            end else begin
              if (early) order_err_out <= 1'b1;
              if (merge) begin
                cur_hi <= new_hi;
              end else begin
                total_out     <= total_out + span;
                intervals_out <= intervals_out + CNT_WIDTH'(1);
                cur_lo        <= first;
                cur_hi        <= second;
              end
            end
          end
          if (stream_done_in) state <= FLUSH;
        end
        FLUSH: begin
          if (have_cur) begin
            total_out     <= total_out + span;
            intervals_out <= intervals_out + CNT_WIDTH'(1);
          end
          state <= DONE;
        end
        IDLE, DONE: state <= state;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_union_count.sv
// tb_range_union_count
//   Directed vectors with hand-computed expectations for range_union_count
//   (DATA_WIDTH = 8, SUM_WIDTH = 64, CNT_WIDTH = 16).

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_range_union_count;
  import range_union_pkg::*;

  localparam int SW = 64;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_in;
  logic          pair_valid_in;
  tuple_pair_t   pair_in;
  logic          stream_done_in;
  logic          pair_ready_out;
  logic [SW-1:0] total_out;
  logic [CW-1:0] intervals_out;
  logic          done_out;
  logic          bad_pair_out;
  logic          order_err_out;

  int checks = 0;
  int errors = 0;

  range_union_count #(.SUM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_in       (start_in),
    .pair_valid_in  (pair_valid_in),
    .pair_in        (pair_in),
    .stream_done_in (stream_done_in),
    .pair_ready_out (pair_ready_out),
    .total_out      (total_out),
    .intervals_out  (intervals_out),
    .done_out       (done_out),
    .bad_pair_out   (bad_pair_out),
    .order_err_out  (order_err_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] f, input logic [7:0] s, input logic d);
    pair_valid_in  = 1'b1;
    pair_in.first  = f;
    pair_in.second = s;
    stream_done_in = d;
    tick();
    pair_valid_in  = 1'b0;
    stream_done_in = 1'b0;
  endtask

  task automatic done_alone();
    stream_done_in = 1'b1;
    tick();
    stream_done_in = 1'b0;
  endtask

  // called right after stream_done was sampled: FLUSH now, DONE one cycle later
  task automatic expect_done(input string tag);
    chk({tag, "_flush_done"}, done_out, 1'b0);
    tick();
    chk({tag, "_done"}, done_out, 1'b1);
  endtask

  initial begin
    reset          = 1'b1;
    start_in       = 1'b0;
    pair_valid_in  = 1'b0;
    stream_done_in = 1'b0;
    pair_in        = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_total", total_out, 0);
    chk("rst_intervals", intervals_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_ready", pair_ready_out, 0);
    chk("rst_bad", bad_pair_out, 0);
    chk("rst_order", order_err_out, 0);

    // IDLE ignores pairs and stream_done
    send(8'd1, 8'd4, 1'b1);
    tick();
    chk("idle_total", total_out, 0);
    chk("idle_done", done_out, 0);

    // overlapping pairs, stream_done with the last pair
    start_pulse();
    chk("a_ready", pair_ready_out, 1);
    send(8'd3, 8'd5, 1'b0);
    send(8'd10, 8'd14, 1'b0);
    send(8'd12, 8'd18, 1'b0);
    send(8'd16, 8'd20, 1'b1);
    chk("a_flush_ready", pair_ready_out, 0);
    expect_done("a");
    chk("a_total", total_out, 14);
    chk("a_intervals", intervals_out, 2);
    chk("a_bad", bad_pair_out, 0);
    chk("a_order", order_err_out, 0);
    // held in DONE, pairs ignored
    send(8'd100, 8'd120, 1'b0);
    tick();
    chk("a_hold_total", total_out, 14);
    chk("a_hold_done", done_out, 1);

    // adjacency merges, stream_done alone
    start_pulse();
    chk("b_cleared_done", done_out, 0);
    chk("b_cleared_total", total_out, 0);
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    done_alone();
    expect_done("b");
    chk("b_total", total_out, 5);
    chk("b_intervals", intervals_out, 2);

    // empty stream, then a dropped bad pair
    start_pulse();
    done_alone();
    expect_done("c");
    chk("c_total", total_out, 0);
    chk("c_intervals", intervals_out, 0);
    start_pulse();
    send(8'd9, 8'd2, 1'b0);
    send(8'd4, 8'd6, 1'b1);
    expect_done("d");
    chk("d_bad", bad_pair_out, 1);
    chk("d_total", total_out, 3);
    chk("d_intervals", intervals_out, 1);
    chk("d_order", order_err_out, 0);

    // merge compare must not wrap at all-ones
    start_pulse();
    chk("e_bad_cleared", bad_pair_out, 0);
    send(8'd0, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    expect_done("e");
    chk("e_total", total_out, 256);
    chk("e_intervals", intervals_out, 1);

    // out-of-order pair clamps to cur_lo and merges
    start_pulse();
    send(8'd10, 8'd12, 1'b0);
    send(8'd5, 8'd6, 1'b1);
    expect_done("f");
    chk("f_order", order_err_out, 1);
    chk("f_total", total_out, 3);
    chk("f_intervals", intervals_out, 1);

    // reset mid-RUN discards everything; pairs ignored until start
    start_pulse();
    send(8'd1, 8'd5, 1'b0);
    reset         = 1'b1;
    pair_valid_in = 1'b1;
    tick();
    reset         = 1'b0;
    pair_valid_in = 1'b0;
    chk("g_total", total_out, 0);
    chk("g_intervals", intervals_out, 0);
    chk("g_ready", pair_ready_out, 0);
    chk("g_done", done_out, 0);
    send(8'd7, 8'd9, 1'b0);
    send(8'd20, 8'd29, 1'b1);
    tick();
    tick();
    chk("g_ignored_total", total_out, 0);
    chk("g_ignored_done", done_out, 0);

    // reset beats start in the same cycle
    reset    = 1'b1;
    start_in = 1'b1;
    tick();
    reset    = 1'b0;
    start_in = 1'b0;
    chk("h_reset_prio_ready", pair_ready_out, 0);

    // clean stream after recovery
    start_pulse();
    send(8'd2, 8'd4, 1'b1);
    expect_done("i");
    chk("i_total", total_out, 3);
    chk("i_intervals", intervals_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_union_count.md
RANGE_UNION_COUNT -- requirements
Module: range_union_count

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 64, width of the covered-ID accumulator (SUM_WIDTH > `DATA_WIDTH).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the disjoint-interval counter.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_in  input  1  pulse; clears results and opens a new stream.
REQ-006 pair_valid_in  input  1  pair_in holds a range this cycle.
REQ-007 pair_in  input  tuple_pair_t  inclusive range {first, second}, `DATA_WIDTH each, sorted ascending by first.
REQ-008 stream_done_in  input  1  pulse; no further pairs follow; may coincide with the final valid pair.
REQ-009 pair_ready_out  output  1  block accepts pair_in this cycle.
REQ-010 total_out  output  SUM_WIDTH  count of distinct IDs covered by the union of all accepted ranges.
REQ-011 intervals_out  output  CNT_WIDTH  number of disjoint intervals in the union.
REQ-012 done_out  output  1  total_out and intervals_out final.
REQ-013 bad_pair_out  output  1  sticky; a pair with first > second was dropped.
REQ-014 order_err_out  output  1  sticky; a pair arrived with first < current interval low.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-016 IDLE: pair_ready_out=0, pair_valid_in and stream_done_in ignored; start_in -> RUN.
REQ-017 start_in in any state SHALL clear total, intervals, both error flags, have_cur, and enter RUN next cycle; start_in has priority over every other input.
REQ-018 RUN: pair_ready_out=1; a pair is accepted when pair_valid_in=1 (one pair per cycle, no backpressure in RUN).
REQ-019 Accepted pair with first > second: dropped, bad_pair_out set, no other state change.
REQ-020 First valid pair after start: cur_lo=first, cur_hi=second, have_cur=1.
REQ-021 Subsequent pair merges when first <= cur_hi+1, comparison in `DATA_WIDTH+1 bits (no wrap at all-ones); merge sets cur_hi=max(cur_hi, second), cur_lo unchanged.
REQ-022 Non-merging pair: total += cur_hi-cur_lo+1 (SUM_WIDTH, zero-extended), intervals += 1, cur_lo/cur_hi loaded from pair.
REQ-023 Pair with first < cur_lo: order_err_out set; pair processed by REQ-021 as if first = cur_lo.
REQ-024 stream_done_in in RUN -> FLUSH; a valid pair in the same cycle is processed first.
REQ-025 FLUSH (one cycle, pair_ready_out=0): if have_cur, total += cur_hi-cur_lo+1 and intervals += 1; -> DONE.
REQ-026 DONE: done_out=1, pair_ready_out=0, outputs held stable until start_in or reset.
REQ-027 Latency: done_out rises exactly 2 cycles after the cycle stream_done_in is sampled in RUN.
REQ-028 Empty stream (stream_done_in with no accepted pairs): total_out=0, intervals_out=0.
REQ-029 Accumulator and counter SHALL wrap modulo 2^SUM_WIDTH / 2^CNT_WIDTH; no saturation.
REQ-030 total_out and intervals_out SHALL be driven directly from registers.

Reset
REQ-031 reset SHALL force IDLE; total_out=0, intervals_out=0, done_out=0, pair_ready_out=0, bad_pair_out=0, order_err_out=0, have_cur=0.
REQ-032 reset asserted mid-RUN or mid-FLUSH SHALL discard partial results; the next stream requires start_in.
REQ-033 reset SHALL take priority over start_in in the same cycle.

Verification
REQ-034 start; pairs 3-5, 10-14, 12-18, 16-20; stream_done with the last pair -> total_out=14, intervals_out=2, done_out 2 cycles later, no errors.
REQ-035 start; pairs 1-2, 3-4, 7-7; stream_done alone -> total_out=5, intervals_out=2 (adjacency merges).
REQ-036 start; stream_done with no pairs -> total_out=0, intervals_out=0, done_out=1; then start; pair 9-2, pair 4-6 -> bad_pair_out=1, total_out=3.
REQ-037 start; pairs 0-(2^DATA_WIDTH-1), (2^DATA_WIDTH-1)-(2^DATA_WIDTH-1) -> total_out=2^DATA_WIDTH, intervals_out=1 (no compare wrap).
REQ-038 start; pairs 10-12, 5-6 -> order_err_out=1, total_out=3, intervals_out=1.
REQ-039 start; pairs 1-5; reset mid-RUN -> all outputs 0, IDLE; valid pairs ignored until start_in.
